// File: rtl/kyber_pkg.sv
// Shared constants for the Kyber inverse-NTT controller:
// modulus, scaling factor, zeta table, FSM encoding, reduction.
package kyber_pkg;

  localparam int DW = 16;
  localparam int AW = 8;

  localparam logic [DW-1:0] Q     = 16'd3329;
  localparam logic [DW-1:0] N_INV = 16'd3303;

  localparam int LOG2_N = 8;
  localparam int LAYERS = 7;

  localparam logic [24:0] BARRETT_M = 25'((64'd1 << 36) / 64'd3329);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WT   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;

  // ZETA[i] = 17^bitrev7(i) mod q, plain domain
  localparam logic [11:0] ZETA [128] = '{
    12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
    12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
    12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
    12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
    12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
    12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
    12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
    12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
    12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
    12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
    12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
    12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
    12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
    12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
    12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
    12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
  };

  // Barrett estimate is at most one short, so one subtract finishes it
  function automatic logic [DW-1:0] mod_q(input logic [31:0] x);
    logic [56:0] t;
    logic [31:0] qt;
    logic [31:0] r;
    t  = 57'(x) * 57'(BARRETT_M);
    qt = 32'(t >> 36);
    r  = x - qt * 32'(Q);
    if (r >= 32'(Q)) r = r - 32'(Q);
    return DW'(r);
  endfunction

endpackage

// File: rtl/kyber_gs_butterfly.sv
// Gentleman-Sande butterfly mod q:
// upper = u + v, lower = zeta * (v - u).
module kyber_gs_butterfly
  import kyber_pkg::*;
(
  input  logic [DW-1:0] u,
  input  logic [DW-1:0] v,
  input  logic [DW-1:0] zeta,
  output logic [DW-1:0] upper,
  output logic [DW-1:0] lower
);

  localparam logic [DW:0] QX = {1'b0, Q};

  logic [DW:0] sum;
  logic [DW:0] sum_red;
  logic [DW:0] diff;
  logic [DW:0] diff_red;
  logic [31:0] prod;

  always_comb begin
    sum      = {1'b0, u} + {1'b0, v};
    sum_red  = (sum >= QX) ? sum - QX : sum;
    diff     = {1'b0, v} + QX - {1'b0, u};
    diff_red = (diff >= QX) ? diff - QX : diff;
    prod     = 32'(zeta) * 32'(diff_red);
    upper    = DW'(sum_red);
    lower    = mod_q(prod);
  end

endmodule

// File: rtl/kyber_intt_ctrl.sv
// In-place Kyber inverse NTT sequencer over a dual-port
// 256x16 RAM, followed by the 1/128 scaling pass.
module kyber_intt_ctrl
  import kyber_pkg::*;
#(
  parameter int DATA_WIDTH = DW,
  parameter int ADDR_WIDTH = AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  // j inserts a zero at bit log2(len) of the pair index
  function automatic logic [15:0] addr_pair(
    input logic       scl,
    input logic [2:0] lay,
    input logic [6:0] pr
  );
    logic [2:0] lg;
    logic [7:0] pe;
    logic [7:0] len;
    logic [7:0] j;
    lg  = lay + 3'd1;
    pe  = {1'b0, pr};
    len = 8'd1 << lg;
    j   = ((pe >> lg) << (lg + 3'd1)) | (pe & (len - 8'd1));
    if (scl) return {pr, 1'b0, pr, 1'b1};
    return {j, j | len};
  endfunction

  logic [2:0] state;
  logic       sc;
  logic [2:0] layer;
  logic [6:0] pair;
  logic [6:0] k;

  logic       nxt_sc;
  logic [2:0] nxt_layer;
  logic [6:0] nxt_pair;
  logic [6:0] nxt_k;
  logic       last;
  logic       grp_end;
  logic [7:0] gmask;
  logic [15:0] nxt_addr;
  logic [15:0] first_addr;

  logic [DW-1:0] bf_u;
  logic [DW-1:0] bf_v;
  logic [DW-1:0] bf_z;
  logic [DW-1:0] up0;
  logic [DW-1:0] lo0;
  logic [DW-1:0] lo1;
  logic [DW-1:0] up_unused;

  always_comb begin
    gmask     = (8'd1 << (layer + 3'd1)) - 8'd1;
    grp_end   = (({1'b0, pair} & gmask) == gmask);
    last      = sc && (pair == 7'd127);
    nxt_sc    = sc;
    nxt_layer = layer;
    nxt_pair  = pair + 7'd1;
    nxt_k     = k;
    if (!sc) begin
      if (grp_end) nxt_k = k - 7'd1;
      if (pair == 7'd127) begin
        if (layer == 3'd6) nxt_sc = 1'b1;
        else nxt_layer = layer + 3'd1;
      end
    end
    nxt_addr   = addr_pair(nxt_sc, nxt_layer, nxt_pair);
    first_addr = addr_pair(1'b0, 3'd0, 7'd0);
  end

  // scaling reuses the lower output: 0 as u, N_INV as zeta
  always_comb begin
    bf_u = sc ? '0 : ram_dout_a;
    bf_v = sc ? ram_dout_a : ram_dout_b;
    bf_z = sc ? N_INV : DW'(ZETA[k]);
  end

  kyber_gs_butterfly u_bf0 (
    .u    (bf_u),
    .v    (bf_v),
    .zeta (bf_z),
    .upper(up0),
    .lower(lo0)
  );

  kyber_gs_butterfly u_bf1 (
    .u    ('0),
    .v    (ram_dout_b),
    .zeta (N_INV),
    .upper(up_unused),
    .lower(lo1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_we_a   <= 1'b0;
      ram_we_b   <= 1'b0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_din_a  <= '0;
      ram_din_b  <= '0;
      sc         <= 1'b0;
      layer      <= '0;
      pair       <= '0;
      k          <= 7'd127;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RD;
            busy       <= 1'b1;
            ram_addr_a <= ADDR_WIDTH'(first_addr[15:8]);
            ram_addr_b <= ADDR_WIDTH'(first_addr[7:0]);
          end
        end
        S_RD: state <= S_WT;
        S_WT: state <= S_EX;
        S_EX: begin
          state     <= S_WR;
          ram_we_a  <= 1'b1;
          ram_we_b  <= 1'b1;
          ram_din_a <= DATA_WIDTH'(sc ? lo0 : up0);
          ram_din_b <= DATA_WIDTH'(sc ? lo1 : lo0);
        end
        S_WR: begin
          ram_we_a <= 1'b0;
          ram_we_b <= 1'b0;
          if (last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sc    <= 1'b0;
            layer <= '0;
            pair  <= '0;
            k     <= 7'd127;
          end else begin
            state      <= S_RD;
            sc         <= nxt_sc;
            layer      <= nxt_layer;
            pair       <= nxt_pair;
            k          <= nxt_k;
            ram_addr_a <= ADDR_WIDTH'(nxt_addr[15:8]);
            ram_addr_b <= ADDR_WIDTH'(nxt_addr[7:0]);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_intt_ctrl.sv
// Bench for kyber_intt_ctrl: RAM model, golden forward NTT,
// table of patterns plus reset / restart corner sequences.
module tb_kyber_intt_ctrl;

  localparam int QM = 3329;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic we_a, we_b;
  logic [7:0] addr_a, addr_b;
  logic [15:0] din_a, din_b, dout_a, dout_b;

  always #5 clk = ~clk;

  kyber_intt_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_we_a  (we_a),
    .ram_addr_a(addr_a),
    .ram_din_a (din_a),
    .ram_dout_a(dout_a),
    .ram_we_b  (we_b),
    .ram_addr_b(addr_b),
    .ram_din_b (din_b),
    .ram_dout_b(dout_b)
  );

  logic [15:0] mem [256];
  logic [15:0] load_buf [256];
  logic        load_en = 1'b0;
  logic        seen;
  logic [7:0]  fa, fb;
  logic [15:0] fda, fdb;
  int          nwrites;
  int          bad_writes;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= load_buf[i];
      seen       <= 1'b0;
      nwrites    <= 0;
      bad_writes <= 0;
    end else begin
      if (we_a) mem[addr_a] <= din_a;
      if (we_b) mem[addr_b] <= din_b;
      if (we_a) nwrites <= nwrites + 1;
      bad_writes <= bad_writes + int'(we_a && din_a >= 16'd3329)
                               + int'(we_b && din_b >= 16'd3329);
      if (we_a && !seen) begin
        seen <= 1'b1;
        fa   <= addr_a;
        fb   <= addr_b;
        fda  <= din_a;
        fdb  <= din_b;
      end
    end
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end

  typedef struct {
    string name;
    int    kind;
    int    e0;
    int    e1;
    int    lat;
  } vec_t;

  vec_t vt [7];
  int   zg [128];
  int   ga [256];
  int   xv [256];
  int   expv [256];
  int   checks = 0;
  int   errors = 0;

  function automatic int powmod(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % QM;
    return r;
  endfunction

  function automatic int br7(int x);
    int r = 0;
    for (int i = 0; i < 7; i++) if (x[i]) r |= 1 << (6 - i);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic chk_ram(input string name);
    int mism = 0;
    int first = -1;
    for (int i = 0; i < 256; i++)
      if (int'(mem[i]) != expv[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL %s: %0d words differ, first [%0d] got %0d expected %0d",
               name, mism, first, mem[first], expv[first]);
    end
  endtask

  // reference forward NTT, plain domain, in place on ga
  task automatic ntt_gold();
    int k = 1;
    for (int len = 128; len >= 2; len = len >> 1)
      for (int s = 0; s < 256; s += 2 * len) begin
        int z = zg[k];
        k++;
        for (int j = s; j < s + len; j++) begin
          int t = (z * ga[j + len]) % QM;
          ga[j + len] = (ga[j] - t + QM) % QM;
          ga[j] = (ga[j] + t) % QM;
        end
      end
  endtask

  task automatic prep(input int kind, input int e0, input int e1);
    for (int i = 0; i < 256; i++) begin
      xv[i] = int'($urandom_range(0, QM - 1));
      case (kind)
        0: ga[i] = 0;
        1: ga[i] = 1;
        2: ga[i] = (i % 2 == 0) ? 1 : 0;
        3: ga[i] = i % 2;
        default: ga[i] = xv[i];
      endcase
      expv[i] = (kind == 4) ? xv[i] : ((i == 0) ? e0 : ((i == 1) ? e1 : 0));
    end
    if (kind == 4) ntt_gold();
    for (int i = 0; i < 256; i++) load_buf[i] = 16'(ga[i]);
  endtask

  task automatic load_ram();
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic run_xform(input int p1, input int p2, input bit hold,
                           output int lat, output int bcnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    chk("accept_busy", int'(busy), 1);
    bcnt = busy ? 1 : 0;
    lat = -1;
    for (int n = 1; n < 6000; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
      start = hold || n == p1 || n == p2;
    end
    chk("done_busy_low", int'(busy), 0);
  endtask

  task automatic chk_first(input string name);
    int a0 = int'(load_buf[0]);
    int a2 = int'(load_buf[2]);
    chk({name, "_fw_addr_a"}, int'(fa), 0);
    chk({name, "_fw_addr_b"}, int'(fb), 2);
    chk({name, "_fw_upper"}, int'(fda), (a0 + a2) % QM);
    chk({name, "_fw_lower"}, int'(fdb), (zg[127] * ((a2 - a0 + QM) % QM)) % QM);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, lat2, bc2;
    vt[0] = '{"zeros", 0, 0, 0, 4096};
    vt[1] = '{"ones",  1, 1, 1, 4096};
    vt[2] = '{"even",  2, 1, 0, 4096};
    vt[3] = '{"odd",   3, 0, 1, 4096};
    vt[4] = '{"rand0", 4, 0, 0, 4096};
    vt[5] = '{"rand1", 4, 0, 0, 4096};
    vt[6] = '{"rand2", 4, 0, 0, 4096};
    for (int i = 0; i < 128; i++) zg[i] = powmod(17, br7(i));

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we_a", int'(we_a), 0);
    chk("rst_we_b", int'(we_b), 0);
    chk("rst_addr_b", int'(addr_b), 0);
    chk("rst_din_a", int'(din_a), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      prep(vt[v].kind, vt[v].e0, vt[v].e1);
      load_ram();
      run_xform(0, 0, 1'b0, lat, bc);
      chk({vt[v].name, "_latency"}, lat, vt[v].lat);
      chk({vt[v].name, "_busy_cycles"}, bc, vt[v].lat);
      @(posedge clk); #1;
      chk({vt[v].name, "_done_pulse"}, int'(done), 0);
      chk({vt[v].name, "_writes"}, nwrites, 1024);
      chk({vt[v].name, "_range"}, bad_writes, 0);
      chk_first(vt[v].name);
      chk_ram({vt[v].name, "_ram"});
    end

    // asynchronous reset in the middle of a write cycle
    prep(4, 0, 0);
    load_ram();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1499) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_we_a", int'(we_a), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_we_a", int'(we_a), 0);
    chk("mid_rst_we_b", int'(we_b), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    load_ram();
    run_xform(0, 0, 1'b0, lat, bc);
    chk("after_rst_latency", lat, 4096);
    chk_ram("after_rst_ram");

    // stray start pulses while busy
    prep(4, 0, 0);
    load_ram();
    run_xform(10, 2000, 1'b0, lat, bc);
    chk("extra_start_latency", lat, 4096);
    chk("extra_start_busy", bc, 4096);
    chk_ram("extra_start_ram");

    // start held through done: back-to-back transforms
    prep(0, 0, 0);
    load_ram();
    run_xform(0, 0, 1'b1, lat, bc);
    chk("b2b_first_latency", lat, 4096);
    run_xform(0, 0, 1'b0, lat2, bc2);
    chk("b2b_second_latency", lat2, 4096);
    chk("b2b_second_busy", bc2, 4096);
    chk_ram("b2b_ram");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kyber_intt_ctrl.md
Name: kyber_intt_ctrl

Overview:
Inverse-NTT controller for Kyber (q = 3329, n = 256). It performs the full 7-layer Gentleman-Sande inverse transform in place on an external 256x16 dual-port RAM with 1-cycle read latency, then scales every coefficient by 128^-1 mod q. It is the reverse-direction counterpart of the forward NTT datapath: it takes NTT-domain coefficients and returns the normal-domain polynomial in the same RAM.

Parameters:
DATA_WIDTH, 16, coefficient and RAM word width
ADDR_WIDTH, 8, RAM address width (256 words)
Q, 3329, modulus
N_INV, 3303, 128^-1 mod Q (128*3303 = 1 mod 3329)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  begin transform; sampled only in IDLE
busy  out  1  high from the edge that accepts start until the edge that raises done
done  out  1  one-cycle pulse when the RAM holds the final result
ram_we_a  out  1  port A write enable
ram_addr_a  out  8  port A address
ram_din_a  out  16  port A write data
ram_dout_a  in  16  port A read data, valid 1 cycle after the address is sampled
ram_we_b / ram_addr_b / ram_din_b / ram_dout_b: same as port A, for port B

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, done, ram_we_a, ram_we_b = 0; addresses, din, counters = 0; zeta index k = 127.
- All outputs are registered. The RAM is not touched in IDLE.
- FSM: IDLE -> RD -> WT -> EX -> WR -> (RD | IDLE). Each operation takes exactly 4 cycles.
  - RD: drive the addresses; we_a = we_b = 0.
  - WT: wait for RAM latency.
  - EX: ram_dout is valid. At the EX->WR edge, register din_a/din_b from the butterfly outputs and set we_a = we_b = 1; addresses are held.
  - WR: the RAM writes. At the WR exit edge, clear we and advance the counters.
- Phase BF: layers l = 0..6, len = 2<<l (2, 4, ..., 128). Pair index p = 0..127 per layer.
  - j = ((p >> log2 len) << (log2 len + 1)) | (p & (len-1)).
  - addr_a = j, addr_b = j + len.
  - k starts at 127 and decrements once per group (every len pairs), after the group's last WR. k runs 127..1 over the 127 groups.
  - zeta = ZETA[k], where ZETA[i] = 17^bitrev7(i) mod q (plain domain, not Montgomery).
- Butterfly (inputs canonical in [0, q)):
  - upper = (u + v) mod q, written to addr_a.
  - lower = (zeta * ((v - u + q) mod q)) mod q, written to addr_b.
  - Outputs are canonical in [0, q). The internal product width is at least 24 bits, with no truncation before reduction.
- Phase SC: 128 passes, each handling two coefficients at addr_a = 2p and addr_b = 2p + 1. Each is written as (x * N_INV) mod q, using the same 4-state sequence.
- Completion: at the edge ending the final SC WR, set done = 1 for one cycle, busy = 0, we = 0, and return to IDLE.
  - Total: 896 + 128 = 1024 operations = 4096 cycles. done is high during the 4096th cycle after the start-accept edge.
- start while busy: ignored. start held high in IDLE at the edge where done is high: a new transform begins on the next edge (back-to-back is legal).
- rst asserted mid-operation: the FSM aborts immediately and outputs take their reset values. RAM contents are partial/undefined and the caller must reload.
- No bypass path: read data is never forwarded from a pending write. Sequential operations are separated by WR, so none is needed.

Decomposition:
- Package kyber_pkg:
  - Q, N_INV, log2 constants
  - the 128-entry ZETA constant table (bit-reversed powers of 17)
  - FSM state encoding
- Sub-module kyber_gs_butterfly (combinational): u, v, zeta -> upper, lower.
  - Two instances.
  - In BF phase, instance 0 computes the butterfly.
  - In SC phase, each instance is fed u = 0, v = dout_x, zeta = N_INV, and its lower output gives the scaled coefficient.
- The address generator and k counter stay in kyber_intt_ctrl.

Test Plan:
1. RAM all zeros, pulse start -> RAM stays all zeros; busy high for 4096 cycles; done pulses once, 4096 cycles after the accept edge.
2. RAM all ones -> final RAM[0] = 1, RAM[1] = 1, RAM[2..255] = 0.
3. RAM[even] = 1, RAM[odd] = 0 -> RAM[0] = 1, all others 0. RAM[even] = 0, RAM[odd] = 1 -> RAM[1] = 1, all others 0.
4. Random canonical vector x, loaded as a golden forward NTT(x) -> RAM == x exactly. Also: the first WR cycle writes addresses 0 and 2 with values matching the golden model for ZETA[127]; every write is < 3329; 1000 random seeds.
5. Reset mid-run: assert rst = 0 at cycle 1500 -> busy, done, and we go to 0 asynchronously (same cycle). Then release and start again on a reloaded vector -> correct result.
6. Extra start pulses at cycles 10 and 2000 while busy -> ignored, identical result and timing. start held high through done -> second transform begins on the next edge, with the second done 4096 cycles later.
